// File: rtl/dmem_mmio.sv
// Data-memory responder: word RAM with byte-lane stores plus an MMIO
// window holding a transmit FIFO and a free-running cycle counter.
module dmem_mmio #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cyc_q, cyc_d;

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          is_mmio;
  logic          push, pop, push_ok;
  logic          full, empty;
  logic          ovf_set, ovf_clr, cyc_wr;
  logic [31:0]   status;
  logic          unused_addr;

  assign idx     = ALUResult[AW+1:2];
  assign off     = ALUResult[3:2];
  assign is_mmio = ALUResult[31];
  assign unused_addr = ^{ALUResult[30:AW+2], ALUResult[1:0]};

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));

  assign push    = MemWrite & is_mmio & (off == 2'd0) & ByteEn[0];
  assign pop     = out_valid & out_ready;
  // A pop frees the slot the simultaneous push needs, even when full.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign ovf_clr = MemWrite & is_mmio & (off == 2'd1) & WriteData[6];
  assign cyc_wr  = MemWrite & is_mmio & (off == 2'd2);

  assign out_valid = ~empty;
  assign out_data  = fifo_q[rd_q];

  assign status = {25'b0, ovf_q, full, empty, 4'(cnt_q)};

  always_comb begin
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    wr_d  = push_ok ? wr_q + PW'(1) : wr_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    cyc_d = cyc_wr ? 32'd0 : cyc_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      cyc_q <= 32'd0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      cyc_q <= cyc_d;
    end
  end

  // Storage arrays carry no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (MemWrite && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (ByteEn[i]) mem_q[idx][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  always_comb begin
    ReadData = mem_q[idx];
    if (is_mmio) begin
      unique case (off)
        2'd0:    ReadData = 32'd0;
        2'd1:    ReadData = status;
        2'd2:    ReadData = cyc_q;
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM lanes, aliasing,
// FIFO handshake/overflow, cycle counter and async reset.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] STATUS = 32'h8000_0004;
  localparam logic [31:0] CYCLES = 32'h8000_0008;
  localparam logic [31:0] RSVD   = 32'h8000_000C;

  dmem_mmio #(.DEPTH(64), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ByteEn(ByteEn),
    .ReadData(ReadData),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    @(negedge clk);
    MemWrite  = 1'b1;
    ALUResult = a;
    WriteData = d;
    ByteEn    = be;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    ALUResult = a;
    #1;
    d = ReadData;
  endtask

  logic [31:0] rd, c0, c1;

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    ByteEn    = 4'h0;
    out_ready = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    load(STATUS, rd); chk("rst_status", rd, 32'h10);
    load(CYCLES, rd); chk("rst_cycles", rd, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // RAM byte lanes
    store(32'h10, 32'h1122_3344, 4'hF);
    store(32'h10, 32'hAABB_CCDD, 4'h5);
    load(32'h10, rd); chk("ram_lanes", rd, 32'h11BB_33DD);
    store(32'h10, 32'hFFFF_FFFF, 4'h0);
    load(32'h10, rd); chk("ram_be0", rd, 32'h11BB_33DD);

    // Aliasing
    store(32'h00, 32'hCAFE_F00D, 4'hF);
    load(32'h100, rd); chk("alias_100", rd, 32'hCAFE_F00D);
    load(32'h03, rd);  chk("alias_03", rd, 32'hCAFE_F00D);
    load(32'h10, rd);  chk("ram_keep", rd, 32'h11BB_33DD);

    // FIFO order and handshake
    store(TXDATA, 32'h41, 4'h1);
    store(TXDATA, 32'h42, 4'h1);
    store(TXDATA, 32'h43, 4'h1);
    load(STATUS, rd); chk("fifo_st3", rd, 32'h03);
    load(TXDATA, rd); chk("txdata_rd", rd, 32'h0);
    load(RSVD, rd);   chk("rsvd_rd", rd, 32'h0);
    chk("fifo_v1", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    chk("pop0", {24'd0, out_data}, 32'h41);
    @(negedge clk);
    chk("pop1", {24'd0, out_data}, 32'h42);
    @(negedge clk);
    chk("pop2", {24'd0, out_data}, 32'h43);
    @(negedge clk);
    out_ready = 1'b0;
    load(STATUS, rd); chk("fifo_st_e", rd, 32'h10);
    chk("fifo_v0", {31'd0, out_valid}, 32'd0);

    // Full / overflow
    for (int i = 0; i < 5; i++) store(TXDATA, 32'h50 + i, 4'h1);
    load(STATUS, rd); chk("ovf_st", rd, 32'h64);
    store(STATUS, 32'h40, 4'hF);
    load(STATUS, rd); chk("ovf_clr", rd, 32'h24);
    @(negedge clk);
    out_ready = 1'b1;
    MemWrite  = 1'b1;
    ALUResult = TXDATA;
    WriteData = 32'h55;
    ByteEn    = 4'h1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    out_ready = 1'b0;
    load(STATUS, rd); chk("full_pp", rd, 32'h24);
    @(negedge clk);
    out_ready = 1'b1;
    chk("drain0", {24'd0, out_data}, 32'h51);
    @(negedge clk);
    chk("drain1", {24'd0, out_data}, 32'h52);
    @(negedge clk);
    chk("drain2", {24'd0, out_data}, 32'h53);
    @(negedge clk);
    chk("drain3", {24'd0, out_data}, 32'h55);
    @(negedge clk);
    out_ready = 1'b0;
    load(STATUS, rd); chk("drain_e", rd, 32'h10);

    // Cycle counter
    @(posedge clk);
    #1;
    load(CYCLES, c0);
    repeat (10) @(posedge clk);
    #1;
    load(CYCLES, c1);
    chk("cyc_diff", c1 - c0, 32'd10);
    store(CYCLES, 32'h1234, 4'hF);
    load(CYCLES, rd); chk("cyc_wr0", rd, 32'd0);
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    load(CYCLES, rd); chk("cyc_max", rd, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    load(CYCLES, rd); chk("cyc_wrap", rd, 32'd0);

    // Async reset mid-operation
    store(TXDATA, 32'h61, 4'h1);
    store(TXDATA, 32'h62, 4'h1);
    store(TXDATA, 32'h63, 4'h1);
    store(CYCLES, 32'd0, 4'hF);
    repeat (500) @(posedge clk);
    #1;
    load(CYCLES, rd); chk("cyc_500", rd, 32'd500);
    load(STATUS, rd); chk("pre_rst_st", rd, 32'h03);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    load(STATUS, rd); chk("arst_status", rd, 32'h10);
    load(CYCLES, rd); chk("arst_cycles", rd, 32'd0);
    store(TXDATA, 32'h77, 4'h1);
    load(STATUS, rd); chk("rst_store", rd, 32'h10);
    @(negedge clk);
    reset = 1'b0;
    load(32'h10, rd); chk("ram_after_rst", rd, 32'h11BB_33DD);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
